pipe_hazard_ctrl: RTL

Pipeline control block that generates the `en` (advance/hold) and `flush` (bubble) controls consumed by every pipeline register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, branch/jump redirects from EX and data-memory wait states. Each pipe register gives flush priority over en, and this block relies on that. It sits beside the decode stage and keeps saturating stall/flush event counters for performance monitoring.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 7 +
 rtl/sat_counter32.sv | 13 +
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline constants and hazard FSM state encoding
package pipe_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO5 = '0;
  localparam logic [31:0] ZERO32 = '0;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;
endpackage

// File: rtl/sat_counter32.sv
// sat_counter32: 32-bit event counter that sticks at all-ones
module sat_counter32
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= ZERO32;
    else if (inc && count != '1) count <= count + 32'd1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline en/flush generation for load-use, redirect and dmem wait hazards
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_modify_pc,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
);
  state_t state, next_state;
  logic [1:0] redir_cnt, next_redir;
  logic [7:0] wait_cnt, next_wait;
  logic resume, next_resume;
  logic timeout, mem_stall, load_use;
  assign load_use = ex_memread && ex_rd != ZERO5 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign timeout = state == MEM_WAIT && mem_req && !dmem_ready && wait_cnt >= 8'(MEM_TIMEOUT - 1);
  assign mem_stall = mem_req && !dmem_ready && !timeout;
  assign mem_timeout = timeout && !rst;
  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
    {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = '0;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = '1;
    end else if (mem_stall) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
      mem_wb_flush = 1'b1;
    end else if (ex_modify_pc) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state == REDIRECT) begin
      if_id_flush = 1'b1;
    end else if (load_use) begin
      pc_en = 1'b0;
      if_id_en = 1'b0;
      id_ex_flush = 1'b1;
    end
  end
  // A wait entered from REDIRECT freezes redir_cnt and returns there on release
  always_comb begin
    next_state = RUN;
    next_redir = redir_cnt;
    next_wait = 8'd0;
    next_resume = 1'b0;
    if (mem_stall) begin
      next_state = MEM_WAIT;
      next_wait = wait_cnt + 8'd1;
      next_resume = resume || state == REDIRECT;
    end else if (ex_modify_pc) begin
      next_redir = 2'(REDIRECT_CYCLES - 1);
      next_state = REDIRECT_CYCLES > 1 ? REDIRECT : RUN;
    end else if (state == REDIRECT) begin
      next_redir = redir_cnt - 2'd1;
      next_state = redir_cnt <= 2'd1 ? RUN : REDIRECT;
    end else if (state == MEM_WAIT) begin
      next_state = resume ? REDIRECT : RUN;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      redir_cnt <= 2'd0;
      wait_cnt <= 8'd0;
      resume <= 1'b0;
    end else begin
      state <= next_state;
      redir_cnt <= next_redir;
      wait_cnt <= next_wait;
      resume <= next_resume;
    end
  sat_counter32 u_stall (.clk(clk), .rst(rst), .inc(!pc_en), .count(stall_cnt));
  sat_counter32 u_flush (.clk(clk), .rst(rst),
                         .inc(if_id_flush || id_ex_flush || ex_mem_flush || mem_wb_flush),
                         .count(flush_cnt));
endmodule
